// File: rtl/btn_event_ctrl_if.sv
// ----------------------------------------------------------------------------
// btn_event_ctrl_if
// Groups the button/event signals between the board+CPU side and the
// btn_event_ctrl block.
//   btn_raw   : raw bouncy buttons {btnL, btnC, btnR, btnU}
//   ack       : one-cycle pop strobe from the CPU
//   clr_ovr   : clears the sticky overrun flag
//   evt_valid : at least one event queued
//   evt_code  : head event (0 none, 1 add, 2 sub, 3 mul, 4 equals)
//   evt_count : number of queued events (0..2)
//   btn_clean : debounced button levels
//   overrun   : sticky "a press was dropped" flag
// master = board/CPU side, slave = btn_event_ctrl.
// ----------------------------------------------------------------------------
interface btn_event_ctrl_if;
    logic [3:0] btn_raw;
    logic       ack;
    logic       clr_ovr;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic [1:0] evt_count;
    logic [3:0] btn_clean;
    logic       overrun;

    modport master (
        output btn_raw, ack, clr_ovr,
        input  evt_valid, evt_code, evt_count, btn_clean, overrun
    );

    modport slave (
        input  btn_raw, ack, clr_ovr,
        output evt_valid, evt_code, evt_count, btn_clean, overrun
    );
endinterface

// File: rtl/btn_event_ctrl.sv
// ----------------------------------------------------------------------------
// btn_event_ctrl
// Debounces the four calculator push-buttons, turns each press into one
// operation event, arbitrates simultaneous presses and queues up to two
// events for the CPU to poll and acknowledge.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : btn_event_ctrl_if.slave (see interface file for signal list)
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronized cycles before a level is accepted
//   CNT_W           : debounce counter width, must hold DEBOUNCE_CYCLES-1
// ----------------------------------------------------------------------------
module btn_event_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic            clk,
    input  logic            reset,
    btn_event_ctrl_if.slave bus
);
    // State encoding equals the queued event count, so evt_count is r_state.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_ADD  = 3'd1;
    localparam logic [2:0] CODE_SUB  = 3'd2;
    localparam logic [2:0] CODE_MUL  = 3'd3;
    localparam logic [2:0] CODE_EQ   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_clean;
    logic [3:0]       r_clean_d;
    logic [CNT_W-1:0] r_cnt [4];
    logic [1:0]       r_state;
    logic [2:0]       r_head;
    logic [2:0]       r_tail;
    logic             r_ovr;

    logic [3:0]       w_press;
    logic             w_push;
    logic [2:0]       w_code;
    logic             w_multi;
    logic             w_fifo_drop;

    // Two-flop synchronizer followed by a per-bit stability counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_clean   <= '0;
            r_clean_d <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1   <= bus.btn_raw;
            r_sync2   <= r_sync1;
            r_clean_d <= r_clean;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_clean[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_clean[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Rising edges of the clean levels; bit order {L, C, R, U}, priority U > L > C > R.
    always_comb begin
        w_press = r_clean & ~r_clean_d;
        w_push  = 1'b1;
        w_code  = CODE_NONE;
        if (w_press[0])      w_code = CODE_EQ;
        else if (w_press[3]) w_code = CODE_ADD;
        else if (w_press[2]) w_code = CODE_SUB;
        else if (w_press[1]) w_code = CODE_MUL;
        else                 w_push = 1'b0;
        // More than one bit set: clearing the lowest set bit leaves something.
        w_multi     = (w_press & (w_press - 4'd1)) != 4'd0;
        w_fifo_drop = (r_state == ST_TWO) && w_push && !bus.ack;
    end

    // Two-entry event queue; a push coinciding with a pop never overflows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_head  <= CODE_NONE;
            r_tail  <= CODE_NONE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_state <= ST_ONE;
                        r_head  <= w_code;
                    end
                end
                ST_ONE: begin
                    if (w_push && !bus.ack) begin
                        r_state <= ST_TWO;
                        r_tail  <= w_code;
                    end else if (w_push && bus.ack) begin
                        r_head <= w_code;
                    end else if (bus.ack) begin
                        r_state <= ST_EMPTY;
                        r_head  <= CODE_NONE;
                    end
                end
                ST_TWO: begin
                    if (bus.ack) begin
                        r_head <= r_tail;
                        if (w_push) begin
                            r_tail <= w_code;
                        end else begin
                            r_state <= ST_ONE;
                            r_tail  <= CODE_NONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_head  <= CODE_NONE;
                    r_tail  <= CODE_NONE;
                end
            endcase
        end
    end

    // Sticky overrun; a new drop outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     r_ovr <= 1'b0;
        else if (w_multi || w_fifo_drop) r_ovr <= 1'b1;
        else if (bus.clr_ovr)          r_ovr <= 1'b0;
    end

    assign bus.evt_valid = (r_state != ST_EMPTY);
    assign bus.evt_code  = (r_state == ST_EMPTY) ? CODE_NONE : r_head;
    assign bus.evt_count = r_state;
    assign bus.btn_clean = r_clean;
    assign bus.overrun   = r_ovr;
endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Debounces the four calculator push-buttons and turns each press into a single queued operation event that the CPU reads through the memory-mapped I/O block. It sits between the board buttons and the button input port of `dmem_io`. The CPU polls `evt_valid`/`evt_code` and pulses `ack` to consume each event. The block arbitrates simultaneous presses and buffers up to two events, so slow firmware polling never sees a press twice and never silently loses one.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable synchronized cycles needed before a button level is accepted (≥1).
- `CNT_W`, default 16: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.
- `clk` input, 1: system clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-high reset.
- `btn_raw` input, 4: raw buttons `{btnL, btnC, btnR, btnU}` (add, sub, multiply, equals); asynchronous, bouncy.
- `ack` input, 1: one-cycle pulse from the CPU write strobe; pops the head event.
- `clr_ovr` input, 1: clears `overrun`.
- `evt_valid` output, 1: FIFO holds at least one event.
- `evt_code` output, 3: head event. 0 = none, 1 = add (L), 2 = sub (C), 3 = mul (R), 4 = equals (U).
- `evt_count` output, 2: number of queued events (0–2).
- `btn_clean` output, 4: debounced button levels, same bit order as `btn_raw`.
- `overrun` output, 1: sticky flag; set when a press is dropped.

## Operation
- **Reset:** all outputs and state go to 0 immediately. This covers the synchronizer flops, counters, `btn_clean`, the FIFO (EMPTY), `evt_code`, `evt_count` and `overrun`.
- **Synchronizer:** each `btn_raw` bit passes through 2 flops, giving `sync`.
- **Debounce, per bit:**
  - If `sync == btn_clean`, the counter clears to 0.
  - Otherwise, if `counter == DEBOUNCE_CYCLES-1`, then `btn_clean <= sync` and the counter clears.
  - Otherwise the counter increments.
  - Press and release are debounced identically.
- **Edge detect:** a `press[i]` pulse is generated when `btn_clean[i]` is 1 and its previous-cycle value was 0. Holding a button produces exactly one press.
- **Arbitration:** if several `press` bits are high in the same cycle, only the highest-priority one is enqueued. Priority is U > L > C > R. The others are dropped and `overrun` is set.
- **FIFO states:** EMPTY, ONE, TWO. `evt_valid = (state != EMPTY)`. `evt_code` is the head entry, or 0 when EMPTY. `evt_count` is 0, 1 or 2.
- **FIFO transitions (p = arbitrated press present, a = `ack`):**
  - EMPTY: p → ONE. `a` is ignored.
  - ONE: p & !a → TWO. !p & a → EMPTY. p & a → ONE with the new code at the head; no overrun.
  - TWO: !p & a → ONE, with the tail promoted to head. p & a → TWO (pop the head, push the new code); no overrun. p & !a → TWO; the press is dropped and `overrun` is set.
- **Overrun:** `overrun` sets on any dropped press and stays set until `clr_ovr` or `reset`. If a set and a clear occur in the same cycle, set wins.

## Timing
- **Press latency:** let edge k be the first rising edge that samples `btn_raw[i]=1`, with the raw level then held stable. `btn_clean[i]` rises after edge k+N+1 (N = `DEBOUNCE_CYCLES`). The event is enqueued and `evt_valid` rises after edge k+N+2.
- **Glitch rejection:** a raw pulse seen for fewer than N consecutive synchronized cycles produces no `btn_clean` change and no event.
- **Ack:** takes effect at the edge on which `ack` is sampled high. The new `evt_code`/`evt_count` are visible right after that edge. A multi-cycle `ack` pops once per high cycle.
- **Outputs:** all outputs are registered or decoded from registered state; there is no combinational path from `btn_raw` or `ack`.
- **Reset mid-operation:** an asynchronous assert clears everything within the same cycle. After release, a button still held must re-debounce, taking the full N+2 latency from the first edge after reset release.

## Test plan
All scenarios use N = 4.
- **Single press:** reset, release; hold btnL (`btn_raw=4'b1000`) from edge k for 20 cycles → `evt_valid=1`, `evt_code=1`, `evt_count=1` after edge k+6. No second event while held. `ack` → `evt_valid=0`, `evt_code=0`.
- **Glitch:** btnC high for 3 cycles, then low → `btn_clean` stays 0 and `evt_valid` stays 0. A bouncy press with 2-cycle pulses followed by 10 stable cycles → exactly one event, code 2.
- **FIFO full and overrun:** press L, C, R sequentially with no `ack` → `evt_count=2`, head 1, `overrun=1` after the R press. `ack` → head 2. `ack` → EMPTY. `clr_ovr` → `overrun=0`.
- **Simultaneous press:** btnU and btnL rise in the same cycle → one event, code 4, `overrun=1`.
- **Press with ack:** in ONE (code 3) a new press of btnU coincides with `ack` → ONE, code 4, `overrun=0`. In TWO (codes 1, 2) a press of btnR coincides with `ack` → TWO, head 2, tail 3.
- **Reset mid-operation:** assert `reset` while in TWO with btnL held → all outputs 0 immediately. After release with btnL still held → code 1 appears N+2 edges later.
